// File: rtl/zc_pair_writer_if.sv
// Bundle of the lane beat stream and the compressed-activation SRAM write port.
// master drives beats and grants (upstream/arbiter side); slave is the pair writer.
interface zc_pair_writer_if #(
    parameter int unsigned N         = 16,
    parameter int unsigned ADDR_SIZE = 16
);
    logic                 i_valid;
    logic                 o_ready;
    logic [N-1:0]         i_data;
    logic [N-1:0]         i_offset;
    logic                 i_last;
    logic [ADDR_SIZE-1:0] i_base_addr;
    logic                 o_wr_en;
    logic [ADDR_SIZE-1:0] o_wr_addr;
    logic [N-1:0]         o_wr_data;
    logic                 i_wr_gnt;
    logic                 o_done;
    logic [ADDR_SIZE-1:0] o_pair_cnt;

    modport master (
        output i_valid, i_data, i_offset, i_last, i_base_addr, i_wr_gnt,
        input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_done, o_pair_cnt
    );

    modport slave (
        input  i_valid, i_data, i_offset, i_last, i_base_addr, i_wr_gnt,
        output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_done, o_pair_cnt
    );
endinterface

// File: rtl/zc_pair_writer.sv
// Zero-compression pair writer: drops zero values, buffers (value, offset) pairs
// and drains each as two SRAM word writes, closing a brick with an end-marker pair.
module zc_pair_writer #(
    parameter int unsigned N         = 16,
    parameter int unsigned ADDR_SIZE = 16,
    parameter int unsigned DEPTH     = 4
) (
    input logic              clk,
    input logic              rst,
    zc_pair_writer_if.slave  bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StVal,
        StOff,
        StMval,
        StMoff,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [2*N-1:0]       mem_q [DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [ADDR_SIZE-1:0] idx_q, idx_d;
    logic [ADDR_SIZE-1:0] base_q, base_d;
    logic                 last_seen_q, last_seen_d;
    logic                 brick_active_q, brick_active_d;

    logic                 full;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 done_pulse;
    logic [N-1:0]         head_value;
    logic [N-1:0]         head_offset;
    logic [ADDR_SIZE-1:0] addr_even;
    logic [ADDR_SIZE-1:0] addr_odd;

    assign full        = (count_q == CntW'(DEPTH));
    assign bus.o_ready = !full && !last_seen_q;
    assign accept      = bus.i_valid && bus.o_ready;
    assign push        = accept && (bus.i_data != '0);
    // The head pair is only released once its offset word is granted.
    assign pop         = (state_q == StOff) && bus.i_wr_gnt;

    assign head_value  = mem_q[rd_ptr_q][2*N-1:N];
    assign head_offset = mem_q[rd_ptr_q][N-1:0];
    // Address arithmetic wraps modulo 2^ADDR_SIZE.
    assign addr_even   = base_q + idx_q;
    assign addr_odd    = base_q + idx_q + ADDR_SIZE'(1);

    // FIFO storage; contents need no reset since count/pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.i_data, bus.i_offset};
        end
    end

    // FIFO bookkeeping and brick context for the next cycle.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        base_d         = base_q;
        last_seen_d    = last_seen_q;
        brick_active_d = brick_active_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (accept) begin
            if (!brick_active_q) begin
                base_d         = bus.i_base_addr;
                brick_active_d = 1'b1;
            end
            if (bus.i_last) begin
                last_seen_d = 1'b1;
            end
        end

        // Input is blocked while last_seen is set, so DONE never races an accept.
        if (done_pulse) begin
            last_seen_d    = 1'b0;
            brick_active_d = 1'b0;
        end
    end

    // Write-sequencing FSM: next state, idx update and SRAM/done outputs.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        done_pulse     = 1'b0;
        bus.o_wr_en    = 1'b0;
        bus.o_wr_addr  = '0;
        bus.o_wr_data  = '0;
        bus.o_done     = 1'b0;
        bus.o_pair_cnt = '0;

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StVal;
                end else if (last_seen_q) begin
                    state_d = StMval;
                end
            end
            StVal: begin
                bus.o_wr_en   = 1'b1;
                bus.o_wr_addr = addr_even;
                bus.o_wr_data = head_value;
                if (bus.i_wr_gnt) begin
                    state_d = StOff;
                end
            end
            StOff: begin
                bus.o_wr_en   = 1'b1;
                bus.o_wr_addr = addr_odd;
                bus.o_wr_data = head_offset;
                if (bus.i_wr_gnt) begin
                    idx_d = idx_q + ADDR_SIZE'(2);
                    // Decision uses the registered count; a same-cycle push is picked
                    // up from IDLE on the following cycle.
                    if (count_q > CntW'(1)) begin
                        state_d = StVal;
                    end else if (last_seen_q) begin
                        state_d = StMval;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StMval: begin
                bus.o_wr_en   = 1'b1;
                bus.o_wr_addr = addr_even;
                bus.o_wr_data = '0;
                if (bus.i_wr_gnt) begin
                    state_d = StMoff;
                end
            end
            StMoff: begin
                bus.o_wr_en   = 1'b1;
                bus.o_wr_addr = addr_odd;
                bus.o_wr_data = {N{1'b1}};
                if (bus.i_wr_gnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_pulse     = 1'b1;
                bus.o_done     = 1'b1;
                bus.o_pair_cnt = idx_q >> 1;
                idx_d          = '0;
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any brick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            idx_q          <= '0;
            base_q         <= '0;
            last_seen_q    <= 1'b0;
            brick_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            idx_q          <= idx_d;
            base_q         <= base_d;
            last_seen_q    <= last_seen_d;
            brick_active_q <= brick_active_d;
        end
    end
endmodule

// File: tb/tb_zc_pair_writer.sv
// Scoreboard bench for zc_pair_writer: expected SRAM writes and pair counts are
// queued by a reference model as beats are accepted and popped as the DUT writes.
module tb_zc_pair_writer;
    logic clk;
    logic rst;

    zc_pair_writer_if #(.N(16), .ADDR_SIZE(16)) bus ();

    zc_pair_writer #(
        .N         (16),
        .ADDR_SIZE (16),
        .DEPTH     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [31:0] exp_q [$];      // {addr, data}
    logic [15:0] exp_done_q [$]; // pair counts
    int          done_seen = 0;

    // Reference model of the brick context.
    bit          m_active = 0;
    logic [15:0] m_base = '0;
    logic [15:0] m_idx = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [15:0] d, input logic [15:0] off,
                                input bit last, input logic [15:0] base);
        if (!m_active) begin
            m_active = 1;
            m_base   = base;
        end
        if (d != 16'h0) begin
            exp_q.push_back({m_base + m_idx, d});
            exp_q.push_back({m_base + m_idx + 16'd1, off});
            m_idx = m_idx + 16'd2;
        end
        if (last) begin
            exp_q.push_back({m_base + m_idx, 16'h0000});
            exp_q.push_back({m_base + m_idx + 16'd1, 16'hFFFF});
            exp_done_q.push_back(m_idx >> 1);
            m_active = 0;
            m_idx    = '0;
        end
    endtask

    // Offer one beat for up to max_cyc cycles; ok reports whether it was taken.
    task automatic send_beat(input logic [15:0] d, input logic [15:0] off, input bit last,
                             input logic [15:0] base, input int max_cyc, output bit ok);
        ok = 0;
        bus.i_valid     = 1'b1;
        bus.i_data      = d;
        bus.i_offset    = off;
        bus.i_last      = last;
        bus.i_base_addr = base;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                ok = 1;
                model_accept(d, off, last, base);
            end
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic send_ok(input logic [15:0] d, input logic [15:0] off, input bit last,
                           input logic [15:0] base);
        bit ok;
        send_beat(d, off, last, base, 40, ok);
        check_eq("beat_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int max_cyc);
        int start;
        start = done_seen;
        for (int c = 0; c < max_cyc && done_seen == start; c++) begin
            @(posedge clk);
        end
        #1;
        check_eq("done_reached", 32'(done_seen != start), 32'd1);
        check_eq("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard side: compare each granted write and each done pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.o_wr_en && bus.i_wr_gnt) begin
                if (exp_q.size() == 0) begin
                    check_eq("wr_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check_eq("wr_addr", 32'(bus.o_wr_addr), 32'(e[31:16]));
                    check_eq("wr_data", 32'(bus.o_wr_data), 32'(e[15:0]));
                end
            end
            if (bus.o_done) begin
                done_seen++;
                if (exp_done_q.size() == 0) begin
                    check_eq("done_expected", 32'(exp_done_q.size()), 32'd1);
                end else begin
                    check_eq("pair_cnt", 32'(bus.o_pair_cnt), 32'(exp_done_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bit ok;
        int n_ok;

        // Reset held with a valid last beat on the input: nothing may be taken.
        rst             = 1'b0;
        bus.i_wr_gnt    = 1'b1;
        bus.i_valid     = 1'b1;
        bus.i_data      = 16'h0055;
        bus.i_offset    = 16'h0001;
        bus.i_last      = 1'b1;
        bus.i_base_addr = 16'h0010;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
            check_eq("rst_done", 32'(bus.o_done), 32'd0);
        end
        check_eq("rst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(bus.o_wr_data), 32'd0);
        check_eq("rst_pair_cnt", 32'(bus.o_pair_cnt), 32'd0);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(bus.o_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("rst_no_write", 32'(bus.o_wr_en), 32'd0);
        end
        @(posedge clk);
        #1;

        // Basic brick with zero values interleaved.
        send_ok(16'd5, 16'd0, 1'b0, 16'h0100);
        send_ok(16'd0, 16'd1, 1'b0, 16'h0100);
        send_ok(16'd0, 16'd2, 1'b0, 16'h0100);
        send_ok(16'd7, 16'd3, 1'b1, 16'h0100);
        wait_done(100);

        // All-zero brick: only the marker pair.
        for (int i = 0; i < 4; i++) begin
            send_ok(16'd0, 16'(i), (i == 3), 16'h0300);
        end
        wait_done(100);

        // Backpressure: with no grant only DEPTH pairs fit.
        bus.i_wr_gnt = 1'b0;
        n_ok = 0;
        for (int i = 0; i < 4; i++) begin
            send_beat(16'h0011 + 16'(i), 16'(i), 1'b0, 16'h0200, 4, ok);
            n_ok += int'(ok);
        end
        send_beat(16'h0015, 16'd4, 1'b0, 16'h0200, 6, ok);
        n_ok += int'(ok);
        check_eq("bp_accepted", 32'(n_ok), 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_ready", 32'(bus.o_ready), 32'd0);
            check_eq("bp_wr_en", 32'(bus.o_wr_en), 32'd1);
            check_eq("bp_wr_addr", 32'(bus.o_wr_addr), 32'h0200);
            check_eq("bp_wr_data", 32'(bus.o_wr_data), 32'h0011);
        end
        @(posedge clk);
        #1;
        bus.i_wr_gnt = 1'b1;
        send_ok(16'h0015, 16'd4, 1'b0, 16'h0200);
        send_ok(16'h0016, 16'd5, 1'b1, 16'h0200);
        wait_done(100);

        // Address wrap past the top of the SRAM.
        send_ok(16'h0003, 16'd0, 1'b0, 16'hFFFE);
        send_ok(16'h0004, 16'd1, 1'b1, 16'hFFFE);
        wait_done(100);

        // Reset in the offset-write state with the grant low.
        bus.i_wr_gnt = 1'b0;
        send_ok(16'h0021, 16'd0, 1'b0, 16'h0500);
        for (int c = 0; c < 20 && !bus.o_wr_en; c++) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_val_addr", 32'(bus.o_wr_addr), 32'h0500);
        bus.i_wr_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.i_wr_gnt = 1'b0;
        check_eq("mid_off_addr", 32'(bus.o_wr_addr), 32'h0501);
        check_eq("mid_off_data", 32'(bus.o_wr_data), 32'h0000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_done_q.delete();
        m_active = 0;
        m_idx    = '0;
        check_eq("mid_rst_wr_en", 32'(bus.o_wr_en), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        bus.i_wr_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid_rst_empty", 32'(bus.o_wr_en), 32'd0);
        end
        @(posedge clk);
        #1;
        send_ok(16'h0009, 16'd2, 1'b1, 16'h0040);
        wait_done(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/zc_pair_writer.md
Name: zc_pair_writer

Overview:
Downstream stage of the per-lane zero-compression address/offset generator. It takes the lane's stream of (value, offset) beats, drops zero values, and buffers the non-zero pairs in a small FIFO. Each buffered pair is drained to the compressed-activation SRAM write port as two single-word writes: value at base+idx, offset at base+idx+1, with idx advancing by 2. At end of brick it appends an end-marker pair and reports the pair count.

Parameters:
N, 16, data/offset word width
ADDR_SIZE, 16, SRAM address width
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
i_valid  in  1  input beat valid
o_ready  out  1  input beat accepted when i_valid&&o_ready
i_data  in  N  activation value
i_offset  in  N  position of value within brick
i_last  in  1  final beat of brick
i_base_addr  in  ADDR_SIZE  brick base address, sampled on first accepted beat of brick
o_wr_en  out  1  SRAM write request
o_wr_addr  out  ADDR_SIZE  SRAM write address
o_wr_data  out  N  SRAM write data
i_wr_gnt  in  1  write beat completes when o_wr_en&&i_wr_gnt
o_done  out  1  one-cycle end-of-brick pulse
o_pair_cnt  out  ADDR_SIZE  non-zero pairs written in the brick, marker excluded; valid while o_done=1

Behaviour:
- Reset (rst=0 at edge): FIFO empty, idx=0, last_seen=0, brick_active=0, state IDLE. Cycle after reset: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_done=0, o_pair_cnt=0, o_ready=1. Reset mid-operation aborts the brick. No partial write completes after reset.
- o_ready = !full && !last_seen (combinational).
- Accept: if brick_active=0, latch base=i_base_addr and set brick_active. If i_data!=0, push {i_data,i_offset}. Zero data is consumed but not pushed. If i_last=1, set last_seen after the push decision.
- Simultaneous push and pop: count unchanged. A push into a full FIFO cannot occur, because o_ready gates it.
- FSM states: IDLE, VAL, OFF, MVAL, MOFF, DONE.
  - IDLE: if count>0 go to VAL. Else if last_seen go to MVAL. Else stay.
  - VAL: o_wr_en=1, addr=base+idx, data=head.value. On gnt go to OFF.
  - OFF: o_wr_en=1, addr=base+idx+1, data=head.offset. On gnt: pop, idx+=2. Next state is VAL if registered count>1, else MVAL if last_seen, else IDLE. A push in the same cycle is not considered.
  - MVAL: o_wr_en=1, addr=base+idx, data=0. On gnt go to MOFF.
  - MOFF: o_wr_en=1, addr=base+idx+1, data={N{1'b1}}. On gnt go to DONE.
  - DONE: o_done=1, o_pair_cnt=idx>>1. Clear idx, last_seen and brick_active. Go to IDLE.
- The head pair stays in the FIFO until its offset beat is granted, so it occupies a slot while stalled.
- Without gnt, o_wr_en/o_wr_addr/o_wr_data hold stable. Outside write states, o_wr_en=0 and o_wr_addr/o_wr_data=0.
- Throughput with gnt=1 is 2 cycles per pair, back-to-back.
- Arithmetic: address = base+idx (+1), truncated mod 2^ADDR_SIZE, so addresses wrap. idx wraps mod 2^ADDR_SIZE.
- Ordering: pairs are written in acceptance order. The marker is always the last write of a brick.
- Next brick inputs are blocked from i_last acceptance until the DONE cycle. Input is accepted again from the cycle after DONE.

Test Plan:
- Reset: hold rst=0 for 2 cycles with i_valid=1 -> o_wr_en=0, o_done=0, nothing accepted; after release o_ready=1.
- Basic: base=0x0100, data 5,0,0,7 at offsets 0..3 (last on 7), gnt=1 -> writes (0x100,5),(0x101,0),(0x102,7),(0x103,3),(0x104,0),(0x105,0xFFFF); o_done pulses once with o_pair_cnt=2.
- All-zero brick: 4 zero beats, last on 4th -> only (base,0),(base+1,0xFFFF); o_pair_cnt=0.
- Backpressure: DEPTH=4, gnt=0, offer 6 non-zero beats -> exactly 4 accepted and o_ready=0 with o_wr_en held stable. Release gnt -> all 6 pairs written in order, 2 cycles each.
- Wrap: base=0xFFFE, two non-zero beats, last on 2nd -> addresses 0xFFFE,0xFFFF,0x0000,0x0001, marker at 0x0002,0x0003.
- Reset mid-op: assert rst=0 while in OFF with gnt=0 -> next cycle o_wr_en=0 and FIFO empty. A following brick with base=0x0040 writes first at 0x0040.
